// File: rtl/ps2_dev_tx.sv
// ps2_dev_tx: device-side PS/2 transmitter (keyboard end of the link).
// Turns one key event into its set-2 scancode bytes (optional E0 prefix,
// optional F0 break prefix, then the code). Each byte goes out as an
// 11-bit frame on ps2_clk/ps2_data, followed by an idle-high gap.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   key_valid/ready   event handshake; ready is high only when idle
//   key_code          scancode without prefixes
//   key_release       1 = break event (F0 inserted)
//   key_ext           1 = extended key (E0 prefix)
//   ps2_clk/ps2_data  push-pull PS/2 lines, both idle high
//   busy              inverse of key_ready
//   event_done        one-cycle pulse on the last gap cycle of an event
`timescale 1ns/1ps
module ps2_dev_tx #(
  parameter int HALF = 2000,
  parameter int GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_code,
  input  logic       key_release,
  input  logic       key_ext,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       event_done
);

  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             phase_q, phase_d;     // 0 = clock high half, 1 = low half
  logic [3:0]       bit_q, bit_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [1:0]       last_q, last_d;       // index of the final queued byte
  logic [7:0]       byte0_q, byte0_d;
  logic [7:0]       byte1_q, byte1_d;
  logic [7:0]       byte2_q, byte2_d;
  logic             ps2_clk_q, ps2_clk_d;
  logic             ps2_data_q, ps2_data_d;
  logic             key_ready_q, key_ready_d;
  logic             event_done_q, event_done_d;
  logic [7:0]       cur_byte;

  // Line level for frame bit idx: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [3:0] di;
    di = idx - 4'd1;
    case (idx)
      4'd0:    frame_bit = 1'b0;
      4'd9:    frame_bit = ~^b;
      4'd10:   frame_bit = 1'b1;
      default: frame_bit = b[di[2:0]];
    endcase
  endfunction

  always_comb begin
    case (byte_idx_q)
      2'd0:    cur_byte = byte0_q;
      2'd1:    cur_byte = byte1_q;
      default: cur_byte = byte2_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    gcnt_d     = gcnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    last_d     = last_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    byte2_d    = byte2_q;
    ps2_clk_d  = ps2_clk_q;
    ps2_data_d = ps2_data_q;

    case (state_q)
      S_IDLE: begin
        if (key_valid && key_ready_q) begin
          case ({key_ext, key_release})
            2'b00: begin byte0_d = key_code; byte1_d = 8'h00;    byte2_d = 8'h00;    last_d = 2'd0; end
            2'b01: begin byte0_d = 8'hF0;    byte1_d = key_code; byte2_d = 8'h00;    last_d = 2'd1; end
            2'b10: begin byte0_d = 8'hE0;    byte1_d = key_code; byte2_d = 8'h00;    last_d = 2'd1; end
            default: begin byte0_d = 8'hE0;  byte1_d = 8'hF0;    byte2_d = key_code; last_d = 2'd2; end
          endcase
          // Start bit is on the line in the very first cycle after acceptance.
          state_d    = S_FRAME;
          byte_idx_d = 2'd0;
          div_d      = '0;
          phase_d    = 1'b0;
          bit_d      = 4'd0;
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b0;
        end
      end

      S_FRAME: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (!phase_q) begin
            ps2_clk_d = 1'b0;
          end else if (bit_q == 4'd10) begin
            state_d    = S_GAP;
            gcnt_d     = '0;
            ps2_clk_d  = 1'b1;
            ps2_data_d = 1'b1;
          end else begin
            // Data only moves at the start of the high phase.
            bit_d      = bit_q + 4'd1;
            ps2_clk_d  = 1'b1;
            ps2_data_d = frame_bit(cur_byte, bit_q + 4'd1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (gcnt_q == GAP_LAST) begin
            if (byte_idx_q == last_q) begin
              state_d = S_IDLE;
            end else begin
              state_d    = S_FRAME;
              byte_idx_d = byte_idx_q + 2'd1;
              phase_d    = 1'b0;
              bit_d      = 4'd0;
              ps2_clk_d  = 1'b1;
              ps2_data_d = 1'b0;
            end
          end else begin
            gcnt_d = gcnt_q + GAP_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, so derive them from the next state.
    key_ready_d  = (state_d == S_IDLE);
    event_done_d = (state_d == S_GAP) && (div_d == DIV_LAST) &&
                   (gcnt_d == GAP_LAST) && (byte_idx_d == last_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      gcnt_q       <= '0;
      phase_q      <= 1'b0;
      bit_q        <= 4'd0;
      byte_idx_q   <= 2'd0;
      last_q       <= 2'd0;
      byte0_q      <= 8'h00;
      byte1_q      <= 8'h00;
      byte2_q      <= 8'h00;
      ps2_clk_q    <= 1'b1;
      ps2_data_q   <= 1'b1;
      key_ready_q  <= 1'b1;
      event_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      gcnt_q       <= gcnt_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      byte_idx_q   <= byte_idx_d;
      last_q       <= last_d;
      byte0_q      <= byte0_d;
      byte1_q      <= byte1_d;
      byte2_q      <= byte2_d;
      ps2_clk_q    <= ps2_clk_d;
      ps2_data_q   <= ps2_data_d;
      key_ready_q  <= key_ready_d;
      event_done_q <= event_done_d;
    end
  end

  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign key_ready  = key_ready_q;
  assign busy       = ~key_ready_q;
  assign event_done = event_done_q;

endmodule

// File: tb/tb_ps2_dev_tx.sv
`timescale 1ns/1ps
module tb_ps2_dev_tx;

  localparam int HALF = 4;
  localparam int GAP  = 2;
  localparam int EV   = (22 + GAP) * HALF;   // cycles per byte incl. gap = 96

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [7:0] key_code = 8'h00;
  logic       key_release = 1'b0;
  logic       key_ext = 1'b0;
  logic       ps2_clk, ps2_data, busy, event_done;

  ps2_dev_tx #(.HALF(HALF), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_code(key_code), .key_release(key_release), .key_ext(key_ext),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .event_done(event_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [7:0] b; logic p; } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic       ext;
    logic       rel;
    logic [7:0] code;
    logic       par;   // expected odd parity of code
    int         nb;    // expected byte count
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame decoder: samples ps2_data at every ps2_clk falling edge.
  int         nbits = 0;
  logic       mprev = 1'b1;
  logic [10:0] fr;
  exp_t       e;
  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      mprev = 1'b1;
    end else begin
      if (mprev && !ps2_clk) begin
        fr[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("start_bit", int'(fr[0]), 0);
            check("data_byte", int'(fr[8:1]), int'(e.b));
            check("parity_bit", int'(fr[9]), int'(e.p));
            check("stop_bit", int'(fr[10]), 1);
          end
        end
      end
      mprev = ps2_clk;
    end
  end

  task automatic push_event(input logic ext, input logic rel, input logic [7:0] code, input logic par);
    exp_t x;
    if (ext) begin x.b = 8'hE0; x.p = 1'b0; exp_q.push_back(x); end
    if (rel) begin x.b = 8'hF0; x.p = 1'b1; exp_q.push_back(x); end
    x.b = code; x.p = par; exp_q.push_back(x);
  endtask

  // Drive an event and return just after the handshake edge.
  task automatic start_event(input logic ext, input logic rel, input logic [7:0] code);
    int t;
    t = 0;
    @(negedge clk);
    key_ext = ext; key_release = rel; key_code = code; key_valid = 1'b1;
    while (!key_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) check("accept_timeout", t, 0);
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  // Watch cycles 0..nb*EV after a handshake edge.
  task automatic watch_event(input int nb, input int inject_at, input string nm);
    int   falls, done_cyc, done_extra, kr_bad;
    int   ff[3];
    logic prev;
    falls = 0; done_cyc = -1; done_extra = 0; kr_bad = 0; prev = 1'b1;
    ff[0] = -1; ff[1] = -1; ff[2] = -1;
    for (int cyc = 0; cyc <= nb * EV; cyc++) begin
      @(negedge clk);
      if (cyc == inject_at) begin
        key_valid = 1'b1; key_code = 8'h23; key_ext = 1'b0; key_release = 1'b0;
      end
      if (cyc == 0) begin
        check({nm, "_start_data"}, int'(ps2_data), 0);
        check({nm, "_start_clk"}, int'(ps2_clk), 1);
      end
      if (prev && !ps2_clk) begin
        if (falls % 11 == 0 && falls / 11 < 3) ff[falls / 11] = cyc;
        falls++;
      end
      prev = ps2_clk;
      if (cyc < nb * EV) begin
        if (key_ready || !busy) kr_bad++;
        if (event_done) begin
          if (done_cyc < 0) done_cyc = cyc; else done_extra++;
        end
      end else begin
        check({nm, "_ready_after"}, int'(key_ready), 1);
        check({nm, "_busy_after"}, int'(busy), 0);
      end
    end
    check({nm, "_falls"}, falls, 11 * nb);
    check({nm, "_done_cycle"}, done_cyc, nb * EV - 1);
    check({nm, "_done_extra"}, done_extra, 0);
    check({nm, "_ready_low"}, kr_bad, 0);
    for (int j = 0; j < nb; j++) check({nm, "_first_fall"}, ff[j], j * EV + HALF);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h1C, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b1, 8'h15, 1'b0, 2};
    vecs[2] = '{1'b1, 1'b1, 8'h75, 1'b0, 3};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1};
    vecs[4] = '{1'b0, 1'b0, 8'hFF, 1'b1, 1};
    vecs[5] = '{1'b1, 1'b0, 8'h5A, 1'b1, 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", int'(ps2_clk), 1);
    check("rst_ps2_data", int'(ps2_data), 1);
    check("rst_key_ready", int'(key_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_event_done", int'(event_done), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven events
    for (int i = 0; i < 6; i++) begin
      start_event(vecs[i].ext, vecs[i].rel, vecs[i].code);
      push_event(vecs[i].ext, vecs[i].rel, vecs[i].code, vecs[i].par);
      watch_event(vecs[i].nb, -1, $sformatf("vec%0d", i));
    end

    // Request during a frame is ignored, then accepted right after ready
    start_event(1'b0, 1'b0, 8'h1C);
    push_event(1'b0, 1'b0, 8'h1C, 1'b0);
    watch_event(1, 20, "busy_ign");
    @(posedge clk);
    #1 key_valid = 1'b0;
    push_event(1'b0, 1'b0, 8'h23, 1'b0);
    watch_event(1, -1, "held23");

    // Reset in the middle of bit 5
    start_event(1'b0, 1'b0, 8'h1C);
    repeat (42) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_ps2_clk", int'(ps2_clk), 1);
    check("midrst_ps2_data", int'(ps2_data), 1);
    check("midrst_key_ready", int'(key_ready), 1);
    check("midrst_busy", int'(busy), 0);
    begin
      int bad_clk, bad_done;
      bad_clk = 0; bad_done = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (!ps2_clk) bad_clk++;
        if (event_done) bad_done++;
      end
      check("midrst_no_falls", bad_clk, 0);
      check("midrst_no_done", bad_done, 0);
    end

    repeat (4) @(negedge clk);
    check("frames_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
